// File: rtl/elevator_car_ctrl.sv
// Single-car elevator controller: latches floor requests and serves them in SCAN order, drives motor/brake/door and alert LEDs.
// Latency: a request is visible on pending one cycle after sampling; the car reacts the cycle after that; all outputs registered.
// Backpressure: none; req_valid is a plain strobe sampled every cycle, and requests are never dropped unless invalid or redundant.
module elevator_car_ctrl #(
    parameter int N_FLOORS      = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [FLOOR_W-1:0]  req_floor,
    input  logic                sensor_puerta,
    input  logic                sensor_sobrepeso,
    output logic [FLOOR_W-1:0]  floor_out,
    output logic [N_FLOORS-1:0] pending,
    output logic                subiendo_LED,
    output logic                bajando_LED,
    output logic                motor_act_LED,
    output logic                freno_act_LED,
    output logic                puerta_abierta_LED,
    output logic                puerta_cerrada_LED,
    output logic                sensor_puerta_LED,
    output logic                sensor_sobrepeso_LED,
    output logic                ready,
    output logic                fault
);

    localparam int TC_W = $clog2(TRAVEL_CYCLES);
    localparam int DC_W = $clog2(DOOR_CYCLES);
    localparam int RC_W = $clog2(MAX_RETRIES + 1);

    localparam logic [TC_W-1:0]    TRAVEL_LAST = TC_W'(TRAVEL_CYCLES - 1);
    localparam logic [DC_W-1:0]    DOOR_LAST   = DC_W'(DOOR_CYCLES - 1);
    localparam logic [RC_W-1:0]    RETRY_LIMIT = RC_W'(MAX_RETRIES);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_MOVE, S_STOP, S_DOOR_OPEN, S_DOOR_WAIT, S_ALERT, S_DOOR_CLOSE, S_FAULT
    } state_t;

    state_t              state, state_nxt;
    logic                dir, dir_nxt;            // 1 = up
    logic [TC_W-1:0]     travel_cnt, travel_nxt;
    logic [DC_W-1:0]     door_cnt, door_nxt;
    logic [RC_W-1:0]     retry_cnt, retry_nxt;
    logic [FLOOR_W-1:0]  floor_nxt;
    logic [N_FLOORS-1:0] pend_nxt;

    logic subiendo_nxt, bajando_nxt, motor_nxt, freno_nxt;
    logic abierta_nxt, cerrada_nxt, puerta_led_nxt, sobrepeso_led_nxt;
    logic ready_nxt, fault_nxt;

    // One-hot mask of a floor; an index beyond the top floor yields an empty mask,
    // which is what makes out-of-range requests fall away naturally.
    function automatic logic [N_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
        logic [N_FLOORS-1:0] m;
        for (int i = 0; i < N_FLOORS; i++) m[i] = (FLOOR_W'(i) == f);
        return m;
    endfunction

    function automatic logic [N_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
        logic [N_FLOORS-1:0] m;
        for (int i = 0; i < N_FLOORS; i++) m[i] = (FLOOR_W'(i) > f);
        return m;
    endfunction

    function automatic logic [N_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
        logic [N_FLOORS-1:0] m;
        for (int i = 0; i < N_FLOORS; i++) m[i] = (FLOOR_W'(i) < f);
        return m;
    endfunction

    logic                door_busy;
    logic                pend_here, pend_above, pend_below;
    logic [FLOOR_W-1:0]  step_floor;
    logic                alert_entry;

    assign door_busy  = (state == S_DOOR_OPEN) || (state == S_DOOR_WAIT) ||
                        (state == S_ALERT)     || (state == S_DOOR_CLOSE);
    assign pend_here  = |(pending & floor_mask(floor_out));
    assign pend_above = |(pending & above_mask(floor_out));
    assign pend_below = |(pending & below_mask(floor_out));
    // Floor reached at the end of the current travel leg, clamped to the shaft ends.
    assign step_floor = dir ? ((floor_out == TOP_FLOOR) ? floor_out : floor_out + FLOOR_W'(1))
                            : ((floor_out == '0)        ? floor_out : floor_out - FLOOR_W'(1));
    assign alert_entry = (state == S_DOOR_WAIT) && (sensor_puerta || sensor_sobrepeso);

    // State, datapath and output registers; reset parks the car at floor 0, brake on, door closed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= S_IDLE;
            dir                  <= 1'b1;
            travel_cnt           <= '0;
            door_cnt             <= '0;
            retry_cnt            <= '0;
            floor_out            <= '0;
            pending              <= '0;
            subiendo_LED         <= 1'b0;
            bajando_LED          <= 1'b0;
            motor_act_LED        <= 1'b0;
            freno_act_LED        <= 1'b1;
            puerta_abierta_LED   <= 1'b0;
            puerta_cerrada_LED   <= 1'b1;
            sensor_puerta_LED    <= 1'b0;
            sensor_sobrepeso_LED <= 1'b0;
            ready                <= 1'b0;
            fault                <= 1'b0;
        end else begin
            state                <= state_nxt;
            dir                  <= dir_nxt;
            travel_cnt           <= travel_nxt;
            door_cnt             <= door_nxt;
            retry_cnt            <= retry_nxt;
            floor_out            <= floor_nxt;
            pending              <= pend_nxt;
            subiendo_LED         <= subiendo_nxt;
            bajando_LED          <= bajando_nxt;
            motor_act_LED        <= motor_nxt;
            freno_act_LED        <= freno_nxt;
            puerta_abierta_LED   <= abierta_nxt;
            puerta_cerrada_LED   <= cerrada_nxt;
            sensor_puerta_LED    <= puerta_led_nxt;
            sensor_sobrepeso_LED <= sobrepeso_led_nxt;
            ready                <= ready_nxt;
            fault                <= fault_nxt;
        end
    end

    // Next state plus request latch, direction choice, floor stepping and the three counters.
    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir;
        travel_nxt = travel_cnt;
        door_nxt   = door_cnt;
        retry_nxt  = retry_cnt;
        floor_nxt  = floor_out;
        pend_nxt   = pending;

        // A call for the floor whose door is cycling is already being served.
        if (req_valid && !(door_busy && (req_floor == floor_out)))
            pend_nxt = pend_nxt | floor_mask(req_floor);

        case (state)
            S_IDLE: begin
                if (pend_here) begin
                    state_nxt = S_DOOR_OPEN;
                end else if (pend_above || pend_below) begin
                    // With calls on both sides keep sweeping the same way.
                    if (pend_above && !pend_below) dir_nxt = 1'b1;
                    if (pend_below && !pend_above) dir_nxt = 1'b0;
                    travel_nxt = '0;
                    state_nxt  = S_MOVE;
                end
            end
            S_MOVE: begin
                if (travel_cnt == TRAVEL_LAST) begin
                    travel_nxt = '0;
                    floor_nxt  = step_floor;
                    if (|(pending & floor_mask(step_floor)))
                        state_nxt = S_STOP;
                    else if (dir ? !(|(pending & above_mask(step_floor)))
                                 : !(|(pending & below_mask(step_floor))))
                        dir_nxt = !dir;
                end else begin
                    travel_nxt = travel_cnt + TC_W'(1);
                end
            end
            S_STOP: begin
                state_nxt = S_DOOR_OPEN;
            end
            S_DOOR_OPEN: begin
                pend_nxt  = pend_nxt & ~floor_mask(floor_out);
                retry_nxt = '0;
                door_nxt  = DOOR_LAST;
                state_nxt = S_DOOR_WAIT;
            end
            S_DOOR_WAIT: begin
                // A sensor wins over a timer expiring in the same cycle.
                if (sensor_puerta || sensor_sobrepeso)
                    state_nxt = S_ALERT;
                else if (door_cnt == '0)
                    state_nxt = S_DOOR_CLOSE;
                else
                    door_nxt = door_cnt - DC_W'(1);
            end
            S_ALERT: begin
                retry_nxt = retry_cnt + RC_W'(1);
                if (retry_cnt + RC_W'(1) == RETRY_LIMIT) begin
                    state_nxt = S_FAULT;
                end else begin
                    door_nxt  = DOOR_LAST;
                    state_nxt = S_DOOR_WAIT;
                end
            end
            S_DOOR_CLOSE: begin
                state_nxt = S_IDLE;
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output values for the coming state, so every registered output lines up with the state it describes.
    always_comb begin
        motor_nxt    = (state_nxt == S_MOVE);
        freno_nxt    = !motor_nxt;
        subiendo_nxt = motor_nxt && dir_nxt;
        bajando_nxt  = motor_nxt && !dir_nxt;
        abierta_nxt  = (state_nxt == S_DOOR_OPEN) || (state_nxt == S_DOOR_WAIT) ||
                       (state_nxt == S_ALERT)     || (state_nxt == S_FAULT);
        cerrada_nxt  = !abierta_nxt;
        ready_nxt    = (state_nxt == S_DOOR_OPEN);
        fault_nxt    = (state_nxt == S_FAULT);

        // Sticky flags catch the sensor that raised the alert even if it drops during ALERT itself.
        puerta_led_nxt    = sensor_puerta_LED    | ((alert_entry || state == S_ALERT) & sensor_puerta);
        sobrepeso_led_nxt = sensor_sobrepeso_LED | ((alert_entry || state == S_ALERT) & sensor_sobrepeso);
        if (state_nxt == S_DOOR_CLOSE) begin
            puerta_led_nxt    = 1'b0;
            sobrepeso_led_nxt = 1'b0;
        end
    end

endmodule
